// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//
// In-order instruction fetch queue feeding the dispatch stage. Sequential
// instruction words are fetched from a synchronous instruction memory (one
// cycle read latency). They are buffered in a small circular FIFO, and the
// oldest word is presented with a valid flag. Dispatch consumes the head word
// by pulsing Pop. Flush discards all buffered and in-flight words and
// redirects fetch to FlushPC.
//
// Ports:
//   Clock    in   single clock, all state updates on the rising edge
//   Reset    in   synchronous, active-high, overrides every other input
//   Pop      in   dequeue the head entry this cycle (ignored when empty)
//   Flush    in   drop queued/in-flight words, restart fetch at FlushPC
//   FlushPC  in   redirect address, sampled when Flush=1
//   MemRead  out  fetch request this cycle
//   MemAddr  out  fetch address (the PC register)
//   MemData  in   memory read data, valid the cycle after MemRead
//   Instr    out  head entry, 0 when the queue is empty
//   Valid    out  queue non-empty (registered)
//   Count    out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module instruction_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Pop,
    input  logic                     Flush,
    input  logic [ADDR_WIDTH-1:0]    FlushPC,
    output logic                     MemRead,
    output logic [ADDR_WIDTH-1:0]    MemAddr,
    input  logic [DATA_WIDTH-1:0]    MemData,
    output logic [DATA_WIDTH-1:0]    Instr,
    output logic                     Valid,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy including the outstanding request needs one extra bit so
    // that DEPTH itself is representable alongside an in-flight word.
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  in_flight_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] entries [DEPTH];

    // -------------------------------------------------------------------------
    // Derived control
    // -------------------------------------------------------------------------
    logic [CNT_W:0]        occupancy;
    logic                  has_room;
    logic                  write_en;
    logic                  pop_en;
    logic [CNT_W-1:0]      count_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        occupancy  = '0;
        has_room   = 1'b0;
        write_en   = 1'b0;
        pop_en     = 1'b0;
        count_next = count_q;

        // Credit the outstanding request but not a same-cycle pop: the
        // returning word always has a free slot, so no overflow is possible.
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, in_flight_q};
        has_room  = (occupancy < DEPTH_OCC);

        // A response is captured only if its request survived; a flush in
        // the arrival cycle (or reset) drops it.
        write_en  = in_flight_q && !Flush && !Reset;
        pop_en    = Pop && (count_q != '0);

        count_next = count_q + CNT_W'(write_en) - CNT_W'(pop_en);
    end

    assign MemRead = !Reset && !Flush && has_room;
    assign MemAddr = Reset ? '0 : pc_q;

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q        <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            in_flight_q <= 1'b0;
            valid_q     <= 1'b0;
        end else if (Flush) begin
            pc_q        <= FlushPC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            in_flight_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            if (MemRead) begin
                pc_q <= pc_q + ADDR_WIDTH'(1);
            end
            in_flight_q <= MemRead;

            // Pointers are PTR_W bits wide, so they wrap modulo DEPTH.
            if (write_en) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop_en) begin
                head_q <= head_q + PTR_W'(1);
            end

            count_q <= count_next;
            valid_q <= (count_next != '0);
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; stale contents are never visible
    // because Instr is gated by the registered valid flag.
    always_ff @(posedge Clock) begin
        if (write_en) begin
            entries[tail_q] <= MemData;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Valid = valid_q;
    assign Instr = valid_q ? entries[head_q] : '0;
    assign Count = count_q;

endmodule

// File: tb/tb_instruction_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_queue
//
// Bench for instruction_queue. A synchronous memory model returns
// 16'h1000 + address one cycle after each request. A queue-level reference
// model tracks the expected FIFO contents, PC and outstanding request, and a
// compare process checks every DUT output against it on each falling edge.
// Directed scenarios add literal expectations for fill, streaming, empty pop,
// flush, wrap and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_instruction_queue;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          Clock   = 1'b0;
    logic          Reset   = 1'b1;
    logic          Pop     = 1'b0;
    logic          Flush   = 1'b0;
    logic [AW-1:0] FlushPC = '0;
    logic          MemRead;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemData = '0;
    logic [DW-1:0] Instr;
    logic          Valid;
    logic [CW-1:0] Count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clock = ~Clock;

    instruction_queue #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Pop     (Pop),
        .Flush   (Flush),
        .FlushPC (FlushPC),
        .MemRead (MemRead),
        .MemAddr (MemAddr),
        .MemData (MemData),
        .Instr   (Instr),
        .Valid   (Valid),
        .Count   (Count)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'h1000 + DW'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Synchronous instruction memory: data for address A appears the cycle
    // after the request.
    always @(posedge Clock) begin
        if (MemRead === 1'b1) begin
            MemData <= mem_word(MemAddr);
        end
    end

    // -------------------------------------------------------------------------
    // Reference model: a plain queue of words plus the fetch PC and one
    // outstanding request.
    // -------------------------------------------------------------------------
    logic [DW-1:0] mq[$];
    logic [AW-1:0] m_pc          = '0;
    bit            m_inflight    = 1'b0;
    logic [AW-1:0] m_pending     = '0;
    bit            m_known       = 1'b0;

    always @(posedge Clock) begin
        bit fetch;
        fetch = 1'b0;
        if (Reset) begin
            mq.delete();
            m_pc       = '0;
            m_inflight = 1'b0;
            m_known    = 1'b1;
        end else if (Flush) begin
            mq.delete();
            m_pc       = FlushPC;
            m_inflight = 1'b0;
        end else begin
            fetch = (mq.size() + int'(m_inflight)) < DEPTH;
            if (Pop && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (m_inflight) begin
                mq.push_back(mem_word(m_pending));
            end
            if (fetch) begin
                m_pending  = m_pc;
                m_pc       = m_pc + 8'd1;
                m_inflight = 1'b1;
            end else begin
                m_inflight = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clock) begin
        if (m_known) begin
            check("mem_read", 32'(MemRead),
                  32'(!Reset && !Flush && ((mq.size() + int'(m_inflight)) < DEPTH)));
            check("mem_addr", 32'(MemAddr), Reset ? 32'd0 : 32'(m_pc));
            check("valid", 32'(Valid), 32'(mq.size() != 0));
            check("instr", 32'(Instr), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            check("count", 32'(Count), 32'(mq.size()));
        end
    end

    // -------------------------------------------------------------------------
    // Directed scenarios with literal expectations
    // -------------------------------------------------------------------------
    bit            fill_rd    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] fill_addr  [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    bit            fill_valid [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int            fill_count [6] = '{0, 0, 1, 2, 3, 4};
    logic [DW-1:0] wrap_exp   [6] = '{16'h10FE, 16'h10FF, 16'h1000, 16'h1001, 16'h1002, 16'h1003};
    logic [DW-1:0] wrap_got   [6] = '{default: '0};
    int            wrap_n     = 0;

    initial begin
        // Reset and fill: two reset edges, then release with Pop=0.
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            check("fill_mem_read", 32'(MemRead), 32'(fill_rd[c]));
            check("fill_mem_addr", 32'(MemAddr), 32'(fill_addr[c]));
            check("fill_valid", 32'(Valid), 32'(fill_valid[c]));
            check("fill_count", 32'(Count), 32'(fill_count[c]));
            if (fill_valid[c]) begin
                check("fill_instr", 32'(Instr), 32'h1000);
            end
            tick();
        end

        // Streaming: pop every cycle for 10 cycles.
        Pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("stream_instr", 32'(Instr), 32'h1000 + 32'(i));
            check("stream_valid", 32'(Valid), 32'd1);
            check("stream_count_max", 32'(Count <= 3'd4), 32'd1);
            tick();
        end
        Pop = 1'b0;

        // Empty pop: Pop held through reset release while nothing is valid.
        Reset = 1'b1;
        Pop   = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        check("empty_pop_count_c0", 32'(Count), 32'd0);
        tick();
        @(negedge Clock);
        check("empty_pop_count_c1", 32'(Count), 32'd0);
        check("empty_pop_valid_c1", 32'(Valid), 32'd0);
        tick();
        Pop = 1'b0;
        @(negedge Clock);
        check("empty_pop_first_valid", 32'(Valid), 32'd1);
        check("empty_pop_first_instr", 32'(Instr), 32'h1000);
        check("empty_pop_count_c2", 32'(Count), 32'd1);
        tick();
        tick();

        // Flush with a request in flight and three words queued.
        Flush   = 1'b1;
        FlushPC = 8'h40;
        @(negedge Clock);
        check("flush_pre_count", 32'(Count), 32'd3);
        check("flush_mem_read", 32'(MemRead), 32'd0);
        tick();
        Flush = 1'b0;
        @(negedge Clock);
        check("flush_f1_valid", 32'(Valid), 32'd0);
        check("flush_f1_count", 32'(Count), 32'd0);
        check("flush_f1_mem_read", 32'(MemRead), 32'd1);
        check("flush_f1_mem_addr", 32'(MemAddr), 32'h40);
        tick();
        @(negedge Clock);
        check("flush_f2_stale_dropped", 32'(Count), 32'd0);
        tick();
        @(negedge Clock);
        check("flush_f3_valid", 32'(Valid), 32'd1);
        check("flush_f3_instr", 32'(Instr), 32'h1040);
        tick();

        // Pointer and PC wrap: redirect to 8'hFE and pop every other cycle.
        Flush   = 1'b1;
        FlushPC = 8'hFE;
        tick();
        Flush = 1'b0;
        for (int k = 0; k < 40 && wrap_n < 6; k++) begin
            Pop = (k % 2 == 0);
            @(negedge Clock);
            if (Pop && Valid) begin
                wrap_got[wrap_n] = Instr;
                wrap_n++;
            end
            tick();
        end
        Pop = 1'b0;
        check("wrap_words_seen", 32'(wrap_n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("wrap_word", 32'(wrap_got[i]), 32'(wrap_exp[i]));
        end

        // Reset mid-stream while two words are queued.
        Flush   = 1'b1;
        FlushPC = 8'h80;
        tick();
        Flush = 1'b0;
        tick();
        tick();
        tick();
        Reset = 1'b1;
        @(negedge Clock);
        check("midreset_pre_count", 32'(Count), 32'd2);
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        check("midreset_valid", 32'(Valid), 32'd0);
        check("midreset_count", 32'(Count), 32'd0);
        check("midreset_mem_addr", 32'(MemAddr), 32'd0);
        tick();
        tick();
        @(negedge Clock);
        check("midreset_refill_valid", 32'(Valid), 32'd1);
        check("midreset_refill_instr", 32'(Instr), 32'h1000);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
